dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_pkg.sv | 31 +++
 rtl/dmem_ram.sv | 50 +++++
 rtl/dmem_resp.sv | 139 +++++++++++++
 tb/tb_dmem_resp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared request/response types, default sizing and strobe helper for the dmem_resp slice.
package dmem_resp_pkg;

    localparam int unsigned DMEM_DEPTH_DEFAULT   = 32'd4096;
    localparam int unsigned DMEM_LATENCY_DEFAULT = 32'd1;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } mem_out_type;

    // Byte, naturally aligned halfword, full word, or a read.
    function automatic logic wstrb_legal(input logic [3:0] wstrb);
        logic ok;
        case (wstrb)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port byte-enabled word array; one read or one write per enabled cycle.
module dmem_ram #(
    parameter int unsigned DEPTH = 32'd4096,
    parameter int unsigned AW    = 32'd12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Array storage: only strobed lanes change; contents survive reset.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read word only for an enabled read; otherwise the output register returns to zero.
    always_comb begin
        if (en && (wstrb == 4'h0)) begin
            rdata_d = mem_q[idx];
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Output data register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'h0000_0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding request, fixed LATENCY wait cycles, one-cycle response.
// Optional address/strobe error checking is built when DMEM_RESP_ERROR_EN is defined.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_in_type  req_q, req_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    mem_in_type  live_s, req_s;
    logic        go_s, err_s, ram_en_s;
    logic [31:0] ram_rdata_s;
    mem_out_type rsp_s;
    logic        unused_ok_s;

    // Fetches never write, so their strobes are cleared before capture.
    assign live_s = '{valid: mem_valid, instr: mem_instr, addr: mem_addr,
                      wdata: mem_wdata, wstrb: (mem_instr ? 4'h0 : mem_wstrb)};

    // With zero latency the array is accessed on the capture edge, so use the live request.
    assign req_s = (state_q == ST_IDLE) ? live_s : req_q;

`ifdef DMEM_RESP_ERROR_EN
    logic [31:0] offset_s;
    assign offset_s = req_s.addr - BASE;
    assign err_s    = ({1'b0, offset_s} >= (33'(DEPTH) << 2)) || !wstrb_legal(req_s.wstrb);
`else
    assign err_s    = 1'b0;
`endif

    assign unused_ok_s = ^{req_s.addr[31:AW+2], req_s.addr[1:0], req_s.valid, req_s.instr};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Next-state logic; valid is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    req_d = live_s;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: go marks the edge entering RESP, where the array is accessed.
    always_comb begin
        go_s = 1'b0;
        case (state_q)
            ST_IDLE: go_s = mem_valid && (LATENCY == 0);
            ST_WAIT: go_s = (cnt_q == 4'd0);
            ST_RESP: go_s = 1'b0;
            default: go_s = 1'b0;
        endcase
        ram_en_s = go_s && !err_s;
        ready_d  = go_s;
        error_d  = go_s && err_s;
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .en    (ram_en_s),
        .wstrb (req_s.wstrb),
        .idx   (req_s.addr[AW+1:2]),
        .wdata (req_s.wdata),
        .rdata (ram_rdata_s)
    );

    assign rsp_s     = '{ready: ready_q, rdata: ram_rdata_s, error: error_q};
    assign mem_ready = rsp_s.ready;
    assign mem_rdata = rsp_s.rdata;
    assign mem_error = rsp_s.error;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances at LATENCY 1, 0 and 5 sharing clock and reset.
module tb_dmem_resp;

    logic        clock;
    logic        reset;
    logic        valid [3];
    logic        instr [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        error [3];

    int n_vec  = 0;
    int n_miss = 0;
    int lat_cfg [3] = '{1, 0, 5};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    dmem_resp #(.DEPTH(4096), .LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_error(error[0]));

    dmem_resp #(.DEPTH(4096), .LATENCY(0)) u_l0 (
        .clock(clock), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_error(error[1]));

    dmem_resp #(.DEPTH(4096), .LATENCY(5)) u_l5 (
        .clock(clock), .reset(reset), .mem_valid(valid[2]), .mem_instr(instr[2]),
        .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
        .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_error(error[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on instance d; checks response cycle, data, error and that ready drops again.
    task automatic xact(input int d, input string tag, input logic ins, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rd, input logic exp_err);
        int cyc;
        @(negedge clock);
        valid[d] = 1'b1; instr[d] = ins; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
        @(posedge clock); #1;
        valid[d] = 1'b0;
        cyc = 1;
        while (ready[d] !== 1'b1 && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_val({tag, "/cycle"}, 32'(cyc), 32'(lat_cfg[d] + 1));
        check_val({tag, "/rdata"}, rdata[d], exp_rd);
        check_val({tag, "/error"}, {31'b0, error[d]}, {31'b0, exp_err});
        @(posedge clock); #1;
        check_val({tag, "/strobe"}, {31'b0, ready[d]}, 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        logic       seen;
        for (int d = 0; d < 3; d++) begin
            valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val("reset/ready", {31'b0, ready[d]}, 32'd0);
            check_val("reset/rdata", rdata[d], 32'h0);
            check_val("reset/error", {31'b0, error[d]}, 32'd0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;

        // LATENCY=1: full-word, byte and halfword writes, fetch, offset ignore
        xact(0, "l1_wr_full", 1'b0, 32'h10, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0);
        xact(0, "l1_rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0);
        xact(0, "l1_wr_ones", 1'b0, 32'h10, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
        xact(0, "l1_wr_byte", 1'b0, 32'h13, 32'h7700_0000, 4'h8, 32'h0, 1'b0);
        xact(0, "l1_rd_byte", 1'b0, 32'h10, 32'h0, 4'h0, 32'h7711_1111, 1'b0);
        xact(0, "l1_wr_half", 1'b0, 32'h10, 32'h0000_BEEF, 4'h3, 32'h0, 1'b0);
        xact(0, "l1_fetch",   1'b1, 32'h12, 32'h0, 4'hF, 32'h7711_BEEF, 1'b0);
        xact(0, "l1_rd_half", 1'b0, 32'h10, 32'h0, 4'h0, 32'h7711_BEEF, 1'b0);
`ifdef DMEM_RESP_ERROR_EN
        xact(0, "err_range",  1'b0, 32'h4000, 32'h0, 4'h0, 32'h0, 1'b1);
        xact(0, "err_strb5",  1'b0, 32'h10, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b1);
        xact(0, "err_keep",   1'b0, 32'h10, 32'h0, 4'h0, 32'h7711_BEEF, 1'b0);
`else
        xact(0, "wrap_rd",    1'b0, 32'h4010, 32'h0, 4'h0, 32'h7711_BEEF, 1'b0);
        xact(0, "strb5_wr",   1'b0, 32'h10, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
        xact(0, "strb5_rd",   1'b0, 32'h10, 32'h0, 4'h0, 32'h77BB_BEDD, 1'b0);
`endif

        // Reset during a live response clears outputs without a clock edge
        @(negedge clock);
        valid[0] = 1'b1; instr[0] = 1'b0; addr[0] = 32'h10; wstrb[0] = 4'h0;
        @(posedge clock); #1; valid[0] = 1'b0;
        @(posedge clock); #1;
        check_val("rst_resp/ready_pre", {31'b0, ready[0]}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("rst_resp/ready", {31'b0, ready[0]}, 32'd0);
        check_val("rst_resp/rdata", rdata[0], 32'h0);
        @(negedge clock); reset = 1'b1;

        // LATENCY=0: write then immediate read, then valid held high
        xact(1, "l0_wr", 1'b0, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        xact(1, "l0_rd", 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        @(negedge clock);
        valid[1] = 1'b1; instr[1] = 1'b0; addr[1] = 32'h40; wstrb[1] = 4'h0;
        pat = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            pat = {pat[6:0], ready[1]};
            if (k == 0) check_val("l0_b2b/rdata", rdata[1], 32'h1234_5678);
        end
        valid[1] = 1'b0;
        check_val("l0_b2b/pattern", {24'b0, pat}, 32'h0000_00AA);

        // LATENCY=5: reset in WAIT drops the pending write
        xact(2, "l5_wr_old", 1'b0, 32'h20, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0);
        @(negedge clock);
        valid[2] = 1'b1; instr[2] = 1'b0; addr[2] = 32'h20; wdata[2] = 32'hDEAD_0000; wstrb[2] = 4'hF;
        @(posedge clock); #1; valid[2] = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_val("l5_rst/ready", {31'b0, ready[2]}, 32'd0);
        check_val("l5_rst/rdata", rdata[2], 32'h0);
        check_val("l5_rst/error", {31'b0, error[2]}, 32'd0);
        @(negedge clock); reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            if (ready[2] === 1'b1) seen = 1'b1;
        end
        check_val("l5_rst/no_resp", {31'b0, seen}, 32'd0);
        xact(2, "l5_rd_old", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
